// File: rtl/tage_index_gen_if.sv
// Lookup request, history update and index/tag result bundle for one tagged TAGE table.
// master = front-end driving requests and history; slave = tage_index_gen.
interface tage_index_gen_if #(
    parameter int IL      = 10,
    parameter int tag_len = 8,
    parameter int PCL     = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [PCL-1:0]     req_pc;
    logic               hist_push;
    logic               hist_bit;
    logic               hist_restore;
    logic               restore_bit;
    logic               out_valid;
    logic [IL-1:0]      out_index;
    logic [tag_len-1:0] out_tag;
    logic               tbl_rd;

    modport master (
        output req_valid, req_pc, hist_push, hist_bit, hist_restore, restore_bit,
        input  req_ready, out_valid, out_index, out_tag, tbl_rd
    );

    modport slave (
        input  req_valid, req_pc, hist_push, hist_bit, hist_restore, restore_bit,
        output req_ready, out_valid, out_index, out_tag, tbl_rd
    );
endinterface

// File: rtl/tage_index_gen.sv
// TAGE index/tag generator: GHR + three folded histories hashed with the PC, one checkpoint.
// Latency 1 cycle from accepted request to out_valid; never stalls (req_ready follows Rst_n).
module tage_index_gen #(
    parameter int IL      = 10,
    parameter int tag_len = 8,
    parameter int HL      = 32,
    parameter int GHL     = 64,
    parameter int PCL     = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    tage_index_gen_if.slave   bus
);
    localparam int CT1W   = tag_len - 1;
    localparam int CI_SH  = HL % IL;
    localparam int CT0_SH = HL % tag_len;
    localparam int CT1_SH = HL % CT1W;

    logic [GHL-1:0]     ghr_q, ghr_d;
    logic [IL-1:0]      ci_q, ci_d;
    logic [tag_len-1:0] ct0_q, ct0_d;
    logic [CT1W-1:0]    ct1_q, ct1_d;

    logic [GHL-1:0]     ck_ghr_q, ck_ghr_d;
    logic [IL-1:0]      ck_ci_q, ck_ci_d;
    logic [tag_len-1:0] ck_ct0_q, ck_ct0_d;
    logic [CT1W-1:0]    ck_ct1_q, ck_ct1_d;

    logic               out_valid_q, out_valid_d;
    logic [IL-1:0]      out_index_q, out_index_d;
    logic [tag_len-1:0] out_tag_q, out_tag_d;

    logic [IL-1:0]      idx_hash;
    logic [tag_len-1:0] tag_hash;

    logic [GHL-1:0]     base_ghr;
    logic [IL-1:0]      base_ci;
    logic [tag_len-1:0] base_ct0;
    logic [CT1W-1:0]    base_ct1;
    logic               shift_en;
    logic               shift_bit;
    logic               old_bit;

    logic               unused_bits;

    always_comb begin
        idx_hash = bus.req_pc[IL+1:2] ^ bus.req_pc[2*IL+1:IL+2] ^ ci_q;
        tag_hash = bus.req_pc[tag_len+1:2] ^ ct0_q ^ {ct1_q, 1'b0};

        out_valid_d = bus.req_valid;
        out_index_d = out_index_q;
        out_tag_d   = out_tag_q;
        ck_ghr_d    = ck_ghr_q;
        ck_ci_d     = ck_ci_q;
        ck_ct0_d    = ck_ct0_q;
        ck_ct1_d    = ck_ct1_q;

        // Hash and snapshot both see this cycle's pre-update history.
        if (bus.req_valid) begin
            out_index_d = idx_hash;
            out_tag_d   = tag_hash;
            ck_ghr_d    = ghr_q;
            ck_ci_d     = ci_q;
            ck_ct0_d    = ct0_q;
            ck_ct1_d    = ct1_q;
        end

        base_ghr  = ghr_q;
        base_ci   = ci_q;
        base_ct0  = ct0_q;
        base_ct1  = ct1_q;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        if (bus.hist_restore) begin
            base_ghr  = ck_ghr_q;
            base_ci   = ck_ci_q;
            base_ct0  = ck_ct0_q;
            base_ct1  = ck_ct1_q;
            shift_en  = 1'b1;
            shift_bit = bus.restore_bit;
        end else if (bus.hist_push) begin
            shift_en  = 1'b1;
            shift_bit = bus.hist_bit;
        end
        old_bit = base_ghr[HL-1];

        ghr_d = ghr_q;
        ci_d  = ci_q;
        ct0_d = ct0_q;
        ct1_d = ct1_q;
        // Folding is a rotate-left with the new bit entering at 0 and the bit leaving the
        // HL window cancelled at position HL mod width.
        if (shift_en) begin
            ghr_d = {base_ghr[GHL-2:0], shift_bit};
            ci_d  = {base_ci[IL-2:0], base_ci[IL-1] ^ shift_bit}
                    ^ (IL'(old_bit) << CI_SH);
            ct0_d = {base_ct0[tag_len-2:0], base_ct0[tag_len-1] ^ shift_bit}
                    ^ (tag_len'(old_bit) << CT0_SH);
            ct1_d = {base_ct1[CT1W-2:0], base_ct1[CT1W-1] ^ shift_bit}
                    ^ (CT1W'(old_bit) << CT1_SH);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ghr_q       <= '0;
            ci_q        <= '0;
            ct0_q       <= '0;
            ct1_q       <= '0;
            ck_ghr_q    <= '0;
            ck_ci_q     <= '0;
            ck_ct0_q    <= '0;
            ck_ct1_q    <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_tag_q   <= '0;
        end else begin
            ghr_q       <= ghr_d;
            ci_q        <= ci_d;
            ct0_q       <= ct0_d;
            ct1_q       <= ct1_d;
            ck_ghr_q    <= ck_ghr_d;
            ck_ci_q     <= ck_ci_d;
            ck_ct0_q    <= ck_ct0_d;
            ck_ct1_q    <= ck_ct1_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.req_ready = Rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.tbl_rd    = out_valid_q;

    assign unused_bits = ^{bus.req_pc, base_ghr[GHL-1]};
endmodule

// File: tb/tb_tage_index_gen.sv
// Directed vector table, folded-history boundary sequences and a random run against a
// GHR model that folds the history window directly.
module tb_tage_index_gen;
    localparam logic [31:0] P = 32'h0000_1004;

    logic Clk;
    logic Rst_n;

    tage_index_gen_if #(.IL(10), .tag_len(8), .PCL(32)) bus ();

    tage_index_gen #(.IL(10), .tag_len(8), .HL(32), .GHL(64), .PCL(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rn;
        logic        req;
        logic [31:0] pc;
        logic        push;
        logic        hb;
        logic        rs;
        logic        rb;
        logic        ev;
        logic [9:0]  ei;
        logic [7:0]  et;
    } vec_t;

    vec_t tbl[26];

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] m_ghr, m_ck;
    logic        m_v;
    logic [9:0]  m_i;
    logic [7:0]  m_t;

    function automatic vec_t mk(logic rn, logic req, logic [31:0] pc, logic push, logic hb,
                                logic rs, logic rb, logic ev, logic [9:0] ei, logic [7:0] et);
        vec_t v;
        v.rn = rn; v.req = req; v.pc = pc; v.push = push; v.hb = hb;
        v.rs = rs; v.rb = rb; v.ev = ev; v.ei = ei; v.et = et;
        return v;
    endfunction

    // XOR of the 32-bit history window cut into w-bit chunks.
    function automatic logic [9:0] fold(logic [63:0] g, int w);
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k % w] = r[k % w] ^ g[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    endtask

    task automatic model_step(input logic rn, input logic req, input logic [31:0] pc,
                              input logic push, input logic hb, input logic rs, input logic rb);
        logic [63:0] nck;
        logic [9:0]  fi, f0, f1;
        if (!rn) begin
            m_ghr = '0; m_ck = '0; m_v = 1'b0; m_i = '0; m_t = '0;
        end else begin
            nck = m_ck;
            fi = fold(m_ghr, 10);
            f0 = fold(m_ghr, 8);
            f1 = fold(m_ghr, 7);
            m_v = req;
            if (req) begin
                m_i = pc[11:2] ^ pc[21:12] ^ fi;
                m_t = pc[9:2] ^ f0[7:0] ^ {f1[6:0], 1'b0};
                nck = m_ghr;
            end
            if (rs)        m_ghr = {m_ck[62:0], rb};
            else if (push) m_ghr = {m_ghr[62:0], hb};
            m_ck = nck;
        end
    endtask

    task automatic apply(input logic rn, input logic req, input logic [31:0] pc,
                         input logic push, input logic hb, input logic rs, input logic rb);
        Rst_n            = rn;
        bus.req_valid    = req;
        bus.req_pc       = pc;
        bus.hist_push    = push;
        bus.hist_bit     = hb;
        bus.hist_restore = rs;
        bus.restore_bit  = rb;
        model_step(rn, req, pc, push, hb, rs, rb);
        #1;
        if (rn) chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [9:0] ei,
                           input logic [7:0] et);
        chk({nm, ".valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
        chk({nm, ".tbl_rd"}, {31'b0, bus.tbl_rd}, {31'b0, ev});
        chk({nm, ".index"}, {22'b0, bus.out_index}, {22'b0, ei});
        chk({nm, ".tag"}, {24'b0, bus.out_tag}, {24'b0, et});
    endtask

    initial begin
        Rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_pc = '0; bus.hist_push = 1'b0; bus.hist_bit = 1'b0;
        bus.hist_restore = 1'b0; bus.restore_bit = 1'b0;
        m_ghr = '0; m_ck = '0; m_v = 1'b0; m_i = '0; m_t = '0;

        //            rn req pc push hb rs rb   ev  idx     tag
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 10'h000, 8'h00);
        tbl[1]  = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h000, 8'h01);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 10'h000, 8'h01);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 10'h000, 8'h00);
        tbl[4]  = mk(1, 0, 0, 1, 1, 0, 0,  0, 10'h000, 8'h00);
        tbl[5]  = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h001, 8'h02);
        tbl[6]  = mk(1, 1, P, 1, 1, 0, 0,  1, 10'h001, 8'h02);
        tbl[7]  = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h003, 8'h04);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 10'h000, 8'h00);
        tbl[9]  = mk(1, 1, P, 1, 1, 0, 0,  1, 10'h000, 8'h01);
        tbl[10] = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h001, 8'h02);
        tbl[11] = mk(1, 0, 0, 1, 1, 0, 0,  0, 10'h001, 8'h02);
        tbl[12] = mk(1, 0, 0, 1, 0, 0, 0,  0, 10'h001, 8'h02);
        tbl[13] = mk(1, 0, 0, 1, 1, 0, 0,  0, 10'h001, 8'h02);
        tbl[14] = mk(1, 0, 0, 1, 1, 0, 0,  0, 10'h001, 8'h02);
        tbl[15] = mk(1, 0, 0, 1, 0, 0, 0,  0, 10'h001, 8'h02);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 1,  0, 10'h001, 8'h02);
        tbl[17] = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h003, 8'h04);
        tbl[18] = mk(1, 0, 0, 1, 1, 1, 0,  0, 10'h003, 8'h04);
        tbl[19] = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h006, 8'h0B);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 10'h000, 8'h00);
        tbl[21] = mk(1, 0, 0, 1, 1, 0, 0,  0, 10'h000, 8'h00);
        tbl[22] = mk(1, 0, 0, 0, 0, 1, 0,  0, 10'h000, 8'h00);
        tbl[23] = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h000, 8'h01);
        tbl[24] = mk(1, 1, P, 1, 0, 1, 1,  1, 10'h000, 8'h01);
        tbl[25] = mk(1, 1, P, 0, 0, 0, 0,  1, 10'h001, 8'h02);

        for (int r = 0; r < 26; r++) begin
            apply(tbl[r].rn, tbl[r].req, tbl[r].pc, tbl[r].push, tbl[r].hb,
                  tbl[r].rs, tbl[r].rb);
            chk_out($sformatf("vec%0d", r), tbl[r].ev, tbl[r].ei, tbl[r].et);
        end

        // Folded-window boundaries: 11 ones, 32 ones, then 32 zeros pushing them all out.
        apply(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 11; k++) apply(1, 0, 0, 1, 1, 0, 0);
        apply(1, 1, P, 0, 0, 0, 0);
        chk_out("ones11", 1'b1, 10'h3FE, 8'h19);
        for (int k = 0; k < 21; k++) apply(1, 0, 0, 1, 1, 0, 0);
        apply(1, 1, P, 0, 0, 0, 0);
        chk_out("ones32", 1'b1, 10'h3FC, 8'h1F);
        for (int k = 0; k < 32; k++) apply(1, 0, 0, 1, 0, 0, 0);
        apply(1, 1, P, 0, 0, 0, 0);
        chk_out("window_exit", 1'b1, 10'h000, 8'h01);

        // Random traffic against the model, with a forced reset in the middle.
        apply(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            logic rn, req, push, hb, rs, rb;
            logic [31:0] pc;
            rn   = (i == 500) ? 1'b0 : ($urandom_range(99) != 0);
            req  = 1'($urandom_range(1));
            pc   = $urandom;
            push = 1'($urandom_range(1));
            hb   = 1'($urandom_range(1));
            rs   = ($urandom_range(7) == 0);
            rb   = 1'($urandom_range(1));
            apply(rn, req, pc, push, hb, rs, rb);
            if (i == 500) chk_out("midrun_reset", 1'b0, 10'h000, 8'h00);
            else          chk_out($sformatf("rnd%0d", i), m_v, m_i, m_t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
